// File: rtl/mem_access_unit_if.sv
// Request/response and data-bus signals of mem_access_unit, grouped for port connection.
// slave is the unit's view; master is the pipeline/bus environment's view.
interface mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [3:0]                mem_ctrl_i;
  logic [ADDR_WIDTH-1:0]     addr_i;
  logic [DATA_WIDTH-1:0]     wdata_i;
  logic                      rsp_valid_o;
  logic [DATA_WIDTH-1:0]     rdata_o;
  logic                      err_o;
  logic                      bus_valid_o;
  logic                      bus_ready_i;
  logic                      bus_we_o;
  logic [DATA_WIDTH/8-1:0]   bus_be_o;
  logic [ADDR_WIDTH-1:0]     bus_addr_o;
  logic [DATA_WIDTH-1:0]     bus_wdata_o;
  logic                      bus_rvalid_i;
  logic [DATA_WIDTH-1:0]     bus_rdata_i;

  modport slave (
    input  req_valid_i, mem_ctrl_i, addr_i, wdata_i,
    input  bus_ready_i, bus_rvalid_i, bus_rdata_i,
    output req_ready_o, rsp_valid_o, rdata_o, err_o,
    output bus_valid_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );

  modport master (
    output req_valid_i, mem_ctrl_i, addr_i, wdata_i,
    output bus_ready_i, bus_rvalid_i, bus_rdata_i,
    input  req_ready_o, rsp_valid_o, rdata_o, err_o,
    input  bus_valid_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage responder: turns MEM_* requests into aligned data-bus accesses
// and returns one formatted (sign/zero-extended) response per accepted request.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_access_unit_if.slave  mau
);

  localparam int unsigned ADDR_OFFSET = DATA_WIDTH / 8;
  localparam int unsigned OFF_W       = $clog2(ADDR_OFFSET);
  localparam int unsigned BE_W        = ADDR_OFFSET;
  localparam bit          WIDE        = (DATA_WIDTH == 64);

  typedef enum logic [3:0] {
    MEM_IDLE = 4'd0,
    MEM_RB   = 4'd1,
    MEM_RBU  = 4'd2,
    MEM_RH   = 4'd3,
    MEM_RHU  = 4'd4,
    MEM_RW   = 4'd5,
    MEM_RWU  = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WH   = 4'd9,
    MEM_WW   = 4'd10,
    MEM_WD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              ctrl_q;
  logic [OFF_W-1:0]        off_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    accept;
  logic                    req_err;
  logic                    req_bus;
  logic [OFF_W-1:0]        off_in;
  logic                    is_store;
  logic                    load_done;
  logic [BE_W-1:0]         be;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_fmt;

  // Extension via left-align then shift back; bits == DATA_WIDTH degenerates to pass-through.
  function automatic logic [DATA_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v,
                                                input int unsigned bits,
                                                input logic sgn);
    logic [DATA_WIDTH-1:0] t;
    t = v << (DATA_WIDTH - bits);
    if (sgn) return $signed(t) >>> (DATA_WIDTH - bits);
    return t >> (DATA_WIDTH - bits);
  endfunction

  assign accept    = mau.req_valid_i && (state_q == IDLE);
  assign off_in    = mau.addr_i[OFF_W-1:0];
  assign is_store  = ctrl_q[3];
  assign load_done = (state_q == WAIT) && mau.bus_rvalid_i && !is_store;

  always_comb begin
    req_err = 1'b0;
    req_bus = 1'b1;
    case (mau.mem_ctrl_i)
      MEM_IDLE:                req_bus = 1'b0;
      MEM_RB, MEM_RBU, MEM_WB: req_err = 1'b0;
      MEM_RH, MEM_RHU, MEM_WH: req_err = off_in[0];
      MEM_RW, MEM_WW:          req_err = |off_in[1:0];
      MEM_RWU:                 req_err = !WIDE || (|off_in[1:0]);
      MEM_RD, MEM_WD:          req_err = !WIDE || (|off_in);
      default:                 req_err = 1'b1;
    endcase
    if (req_err) req_bus = 1'b0;
  end

  always_comb begin
    be = '1;
    case (ctrl_q)
      MEM_WB:  be = BE_W'(1) << off_q;
      MEM_WH:  be = BE_W'(3) << off_q;
      MEM_WW:  be = BE_W'(15) << off_q;
      default: be = '1;
    endcase
  end

  always_comb begin
    shifted  = mau.bus_rdata_i >> {off_q, 3'b000};
    load_fmt = shifted;
    case (ctrl_q)
      MEM_RB:  load_fmt = ext(shifted, 8, 1'b1);
      MEM_RBU: load_fmt = ext(shifted, 8, 1'b0);
      MEM_RH:  load_fmt = ext(shifted, 16, 1'b1);
      MEM_RHU: load_fmt = ext(shifted, 16, 1'b0);
      MEM_RW:  load_fmt = ext(shifted, 32, 1'b1);
      MEM_RWU: load_fmt = ext(shifted, 32, 1'b0);
      default: load_fmt = shifted;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    mau.req_ready_o     = 1'b0;
    mau.rsp_valid_o     = 1'b0;
    mau.rdata_o         = '0;
    mau.err_o           = 1'b0;
    mau.bus_valid_o     = 1'b0;
    mau.bus_we_o        = 1'b0;
    mau.bus_be_o        = '0;
    mau.bus_addr_o      = '0;
    mau.bus_wdata_o     = '0;
    case (state_q)
      IDLE: begin
        mau.req_ready_o = 1'b1;
        if (accept) state_d = req_bus ? REQ : RESP;
      end
      REQ: begin
        mau.bus_valid_o = 1'b1;
        mau.bus_we_o    = is_store;
        mau.bus_be_o    = be;
        mau.bus_addr_o  = addr_q;
        mau.bus_wdata_o = wdata_q << {off_q, 3'b000};
        if (mau.bus_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (mau.bus_rvalid_i) state_d = RESP;
      end
      RESP: begin
        mau.rsp_valid_o = 1'b1;
        mau.rdata_o     = rdata_q;
        mau.err_o       = err_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdata_q is cleared on accept so stores, idles and errors respond with zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      ctrl_q  <= mau.mem_ctrl_i;
      off_q   <= off_in;
      addr_q  <= {mau.addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      wdata_q <= mau.wdata_i;
      rdata_q <= '0;
      err_q   <= req_err;
    end else if (load_done) begin
      rdata_q <= load_fmt;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder that consumes the core's MEM_* control encodings (MEM_IDLE, MEM_RB..MEM_RD, MEM_WB..MEM_WD) and executes them on a word-wide data bus.
- Generates the word-aligned address, byte enables and lane-shifted store data, and waits for the bus handshake.
- Formats load data with sign or zero extension and returns one response per accepted request to write-back.
- Sits between the execute/MEM pipeline register and the data-memory bus.

Parameters:
- DATA_WIDTH, 32, data path width (32 or 64); ADDR_OFFSET = DATA_WIDTH/8 bytes per word.
- ADDR_WIDTH, 32, address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  request valid from pipeline.
- req_ready_o  out  1  unit can accept a request.
- mem_ctrl_i  in  4  MEM_* encoding.
- addr_i  in  ADDR_WIDTH  byte address.
- wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
- rsp_valid_o  out  1  one-cycle response pulse.
- rdata_o  out  DATA_WIDTH  formatted load data; 0 for stores, idle and error responses.
- err_o  out  1  misaligned or illegal access; valid with rsp_valid_o.
- bus_valid_o  out  1  bus request.
- bus_ready_i  in  1  bus accepts request.
- bus_we_o  out  1  1 = write.
- bus_be_o  out  DATA_WIDTH/8  byte enables.
- bus_addr_o  out  ADDR_WIDTH  word-aligned address (low ADDR_OFFSET_WIDTH bits 0).
- bus_wdata_o  out  DATA_WIDTH  lane-shifted store data.
- bus_rvalid_i  in  1  bus completion; also required for writes.
- bus_rdata_i  in  DATA_WIDTH  read data, valid with bus_rvalid_i.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0 except req_ready_o = 1.
  - Internal registers (ctrl, offset, address, data) are cleared.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready_o = 1. Any other state: req_ready_o = 0.
  - A request is accepted when req_valid_i and req_ready_o are both high. The unit then registers mem_ctrl_i, the byte offset addr_i[ADDR_OFFSET_WIDTH-1:0], the aligned address and wdata_i.
  - Accepted legal access → REQ.
  - Accepted MEM_IDLE, misaligned or illegal access → RESP with no bus activity.
- Legality:
  - Halfword requires offset[0] = 0.
  - Word requires offset[1:0] = 0.
  - Doubleword requires offset = 0.
  - MEM_RWU, MEM_RD and MEM_WD are illegal when DATA_WIDTH = 32.
  - Encodings 4'b1100–4'b1111 are illegal.
  - Any illegal or misaligned request sets err_o = 1.
- REQ:
  - bus_valid_o = 1, with bus_we_o, bus_be_o, bus_addr_o and bus_wdata_o driven from the registered request.
  - All bus outputs stay stable until bus_ready_i is high on a rising edge, then → WAIT.
  - bus_valid_o is deasserted in WAIT.
- Byte enables: MEM_WB = 1 << off; MEM_WH = 2'b11 << off; MEM_WW = 4'hF << off; MEM_WD = all ones.
- Loads: bus_be_o = all ones, bus_we_o = 0.
- Store data: bus_wdata_o = wdata << (8*off).
- WAIT: on bus_rvalid_i → RESP. For loads, the formatted data is latched on the same edge:
  - Shift = bus_rdata_i >> (8*off).
  - RB, RH and RW (RW only when DATA_WIDTH = 64) sign-extend bits 7, 15 or 31 respectively.
  - RBU, RHU and RWU zero-extend.
  - RD takes the full word.
  - In RV32, RW is a full-word pass-through.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, with rdata_o and err_o valid, then → IDLE.
  - rdata_o and err_o return to 0 in IDLE.
  - There is no backpressure on the response side.
- Latency:
  - Legal access, accepted at edge N, zero-wait bus: bus_valid_o high during cycle N+1, rvalid during cycle N+2, rsp_valid_o during cycle N+3.
  - Non-bus responses: rsp_valid_o during cycle N+1.
- bus_rvalid_i outside WAIT is ignored.
- Asynchronous reset in any state:
  - Immediately forces reset values. The outstanding bus transaction is abandoned and no response is issued for it.
  - A late bus_rvalid_i arriving after reset is ignored.

Test Plan:
- SB: addr 0x1003, wdata 0x000000AB, zero-wait bus → bus_addr 0x1000, bus_be 4'b1000, bus_wdata 0xAB000000, bus_we 1; rsp_valid pulse with rdata 0, err 0.
- LB then LBU: addr 0x2001, bus_rdata 0x123480FF → rdata 0xFFFFFF80 then 0x00000080.
- LH: addr 0x2002, bus_rdata 0x80010000 → rdata 0xFFFF8001. LH at 0x2001 → rsp_valid one cycle after accept, err 1, bus_valid never asserted.
- SW at 0x3000 with bus_ready low for 3 cycles:
  - bus_valid and all bus signals held stable, req_ready 0.
  - A second req_valid is not accepted.
  - rsp_valid arrives only after bus_ready is seen and then rvalid.
- DATA_WIDTH=32, mem_ctrl MEM_RD or 4'b1101 → err 1, no bus request. MEM_IDLE → rsp_valid, err 0, rdata 0.
- rst_i asserted while in WAIT → outputs zero asynchronously, req_ready 1. A stale rvalid on the next cycle produces no response. A following LW at 0x4000 with rdata 0xDEADBEEF returns 0xDEADBEEF.
